// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: the writeback-source code
// that marks a load, and the state encodings of the MDU and data-memory FSMs.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] RFWSRC_DM = 2'b01;

  localparam int CNT_W = 8;

  typedef enum logic {
    M_RUN  = 1'b0,
    M_BUSY = 1'b1
  } mdu_state_e;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Residency timer for a multi-cycle mul/div sitting in EX.
//
// state  | meaning
// M_RUN  | no MDU op in flight; a start stalls and arms the counter
// M_BUSY | MDU op in EX; counter runs down to 0, then done and back to M_RUN
//
// freeze holds state and counter (data-memory wait has priority) and masks done.
module pipe_hazard_mdu_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic freeze,
  output logic busy,
  output logic done
);

  mdu_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= M_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: arm on start, count down while busy, nothing moves when frozen
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!freeze) begin
      unique case (state_q)
        M_RUN: begin
          if (start) begin
            cnt_d   = CNT_W'(MDU_LAT - 2);
            state_d = M_BUSY;
          end
        end
        M_BUSY: begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
          else             state_d = M_RUN;
        end
        default: state_d = M_RUN;
      endcase
    end
  end

  // outputs: busy is the registered residency flag, done marks the last EX cycle
  always_comb begin
    busy = (state_q == M_BUSY);
    done = (state_q == M_BUSY) && (cnt_q == '0) && !freeze;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Resolves data-memory wait (with watchdog), MDU residency, EX redirects and
// load-use hazards, in that priority order. Stop/flush outputs are combinational.
// Build option: define PIPE_HAZARD_MDU_EN to include the MDU residency timer;
// without it ex_is_mdu is ignored and mdu_done stays 0.
//
// state  | meaning
// M_IDLE | no outstanding data-memory wait
// M_WAIT | access stalled waiting for dm_ack; wait_cnt counts waited cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT     = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rfwaddr,
  input  logic       ex_RFWe,
  input  logic [1:0] ex_RFWsrc,
  input  logic       ex_redirect,
  input  logic       ex_is_mdu,
  input  logic       mem_dm_req,
  input  logic       dm_ack,
  output logic       pc_stop,
  output logic       if_id_stop,
  output logic       id_ex_stop,
  output logic       ex_mem_stop,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       mdu_done,
  output logic       mem_timeout
);

  mem_state_e       mem_state_q, mem_state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_stall, mem_to;
  logic             mdu_busy, mdu_done_w, mdu_stall;
  logic             lu_hit, rd_hit;

`ifdef PIPE_HAZARD_MDU_EN
  pipe_hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (ex_is_mdu),
    .freeze (mem_stall),
    .busy   (mdu_busy),
    .done   (mdu_done_w)
  );
  assign mdu_stall = (ex_is_mdu && !mdu_busy) || (mdu_busy && !mdu_done_w);
`else
  localparam int unused_mdu_lat = MDU_LAT;
  logic unused_mdu_in;
  assign unused_mdu_in = ex_is_mdu;
  assign mdu_busy      = 1'b0;
  assign mdu_done_w    = 1'b0;
  assign mdu_stall     = 1'b0;
`endif

  // mem FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_state_q <= M_IDLE;
      wait_cnt_q  <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // mem wait decode: stall until ack, watchdog fires once wait_cnt reaches the limit
  always_comb begin
    mem_stall = 1'b0;
    mem_to    = 1'b0;
    unique case (mem_state_q)
      M_IDLE: mem_stall = mem_dm_req && !dm_ack;
      M_WAIT: begin
        if (!dm_ack) begin
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) mem_to    = 1'b1;
          else                                   mem_stall = 1'b1;
        end
      end
      default: mem_stall = 1'b0;
    endcase
  end

  // mem FSM next state; the entry cycle already counts as the first waited cycle
  always_comb begin
    mem_state_d = mem_state_q;
    wait_cnt_d  = wait_cnt_q;
    unique case (mem_state_q)
      M_IDLE: begin
        if (mem_stall) begin
          mem_state_d = M_WAIT;
          wait_cnt_d  = CNT_W'(1);
        end
      end
      M_WAIT: begin
        if (dm_ack || mem_to) begin
          mem_state_d = M_IDLE;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d  = wait_cnt_q + 1'b1;
        end
      end
      default: mem_state_d = M_IDLE;
    endcase
  end

  // hazard decode; a redirect is meaningless while EX holds an MDU op
  always_comb begin
    lu_hit = ex_RFWe && (ex_RFWsrc == RFWSRC_DM) && (ex_rfwaddr != 5'd0) &&
             ((id_rs1_used && (id_rs1 == ex_rfwaddr)) ||
              (id_rs2_used && (id_rs2 == ex_rfwaddr)));
    rd_hit = ex_redirect && !mdu_busy;
  end

  // priority mux: mem wait > MDU > redirect > load-use; everything quiet in reset
  always_comb begin
    pc_stop      = 1'b0;
    if_id_stop   = 1'b0;
    id_ex_stop   = 1'b0;
    ex_mem_stop  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    mdu_done     = 1'b0;
    mem_timeout  = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        pc_stop      = 1'b1;
        if_id_stop   = 1'b1;
        id_ex_stop   = 1'b1;
        ex_mem_stop  = 1'b1;
        mem_wb_flush = 1'b1;
      end else begin
        if (mem_to) begin
          mem_timeout  = 1'b1;
          mem_wb_flush = 1'b1;
        end
        mdu_done = mdu_done_w;
        if (mdu_stall) begin
          pc_stop      = 1'b1;
          if_id_stop   = 1'b1;
          id_ex_stop   = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (rd_hit) begin
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
        end else if (lu_hit) begin
          pc_stop      = 1'b1;
          if_id_stop   = 1'b1;
          id_ex_flush  = 1'b1;
        end
      end
    end
  end

endmodule
